// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - device-side PS/2 transmitter: byte FIFO plus 11-bit frame serialiser
// Optional PS2_TX_ERRINJ_EN adds inject_err to corrupt the parity bit of the next popped frame.
module ps2_dev_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef PS2_TX_ERRINJ_EN
  input  logic       inject_err,
`endif
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int DIV_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int DIV_W   = $clog2(DIV_MAX);

  localparam logic [DIV_W-1:0]   HP_LOAD  = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0]   GAP_LOAD = DIV_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t state, state_n;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] w_ptr, r_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop;

  logic [DIV_W-1:0]   div, div_n;
  logic [10:0]        shreg, shreg_n;
  logic [3:0]         bit_idx, bit_idx_n;
  logic               ps2_clk_n, ps2_data_n;
  logic [7:0]         sent_n;
  logic [7:0]         head;
  logic               par;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign tx_ready = ~full;
  assign push     = tx_valid & ~full;
  assign pop      = (state == S_IDLE) & ~empty;
  assign busy     = (state != S_IDLE);
  assign head     = mem[r_ptr];

`ifdef PS2_TX_ERRINJ_EN
  assign par = (~^head) ^ inject_err;
`else
  assign par = ~^head;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[w_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + PTR_ONE;
      if (pop)  r_ptr <= r_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= S_IDLE;
      div      <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      sent_cnt <= '0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      ps2_clk  <= ps2_clk_n;
      ps2_data <= ps2_data_n;
      sent_cnt <= sent_n;
    end
  end

  // shreg[0] always mirrors the bit currently on ps2_data; it shifts only on a rising ps2_clk
  always_comb begin
    state_n    = state;
    div_n      = div;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    ps2_clk_n  = ps2_clk;
    ps2_data_n = ps2_data;
    sent_n     = sent_cnt;
    case (state)
      S_IDLE: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (!empty) begin
          shreg_n    = {1'b1, par, head, 1'b0};
          bit_idx_n  = 4'd0;
          ps2_data_n = 1'b0;
          div_n      = HP_LOAD;
          state_n    = S_HIGH;
        end
      end
      S_HIGH: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = shreg[0];
        if (div == '0) begin
          ps2_clk_n = 1'b0;
          div_n     = HP_LOAD;
          state_n   = S_LOW;
        end else begin
          div_n = div - DIV_ONE;
        end
      end
      S_LOW: begin
        ps2_clk_n = 1'b0;
        if (div == '0) begin
          ps2_clk_n = 1'b1;
          if (bit_idx != 4'd10) begin
            bit_idx_n  = bit_idx + 4'd1;
            shreg_n    = {1'b0, shreg[10:1]};
            ps2_data_n = shreg[1];
            div_n      = HP_LOAD;
            state_n    = S_HIGH;
          end else begin
            ps2_data_n = 1'b1;
            sent_n     = sent_cnt + 8'd1;
            div_n      = GAP_LOAD;
            state_n    = S_GAP;
          end
        end else begin
          div_n = div - DIV_ONE;
        end
      end
      S_GAP: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (div == '0) begin
          state_n = S_IDLE;
        end else begin
          div_n = div - DIV_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - scoreboard bench for ps2_dev_tx: frames, timing, FIFO full, reset
module tb_ps2_dev_tx;
  localparam int HP  = 4;
  localparam int GAP = 8;
  localparam int AW  = 3;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
`ifdef PS2_TX_ERRINJ_EN
  logic       inject_err = 1'b0;
`endif
  logic       tx_ready, ps2_clk, ps2_data, busy;
  logic [7:0] sent_cnt;

  ps2_dev_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_AW(AW)) dut (
    .clk(clk),
    .clrn(clrn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
`ifdef PS2_TX_ERRINJ_EN
    .inject_err(inject_err),
`endif
    .tx_ready(tx_ready),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .busy(busy),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int exp_sent = 0;

  logic [10:0] exp_q[$];
  logic [10:0] rx_q[$];
  int unsigned dur_q[$];
  int unsigned gap_q[$];
  int unsigned start_q[$];
  int unsigned acc_q[$];

  int          bitcnt = 0;
  int          falls = 0;
  int          data_viol = 0;
  int unsigned hi_run = 0;
  int unsigned start_cyc = 0;
  int unsigned last_rise = 0;
  logic [10:0] shv = '0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  // Line monitor: decodes frames on ps2_clk falls, sampled on the idle clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (clrn !== 1'b1) begin
        bitcnt = 0;
        hi_run = 0;
        prev_clk = 1'b1;
        prev_data = 1'b1;
      end else begin
        if (prev_clk && !ps2_clk) begin
          falls++;
          if (bitcnt < 11) begin
            shv[bitcnt] = ps2_data;
            bitcnt++;
          end
        end
        if (!prev_clk && ps2_clk && bitcnt == 11) begin
          rx_q.push_back(shv);
          dur_q.push_back(cyc - start_cyc);
          last_rise = cyc;
          bitcnt = 0;
        end
        if (!prev_clk && !ps2_clk && ps2_data !== prev_data) data_viol++;
        if (prev_data && !ps2_data && ps2_clk && bitcnt == 0) begin
          start_cyc = cyc;
          start_q.push_back(cyc);
          gap_q.push_back(hi_run);
        end
        if (ps2_clk && ps2_data) hi_run++;
        else hi_run = 0;
        prev_clk = ps2_clk;
        prev_data = ps2_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int unsigned obs, input int unsigned min);
    n_checks++;
    assert (obs >= min) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, min);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with tx_valid still high
  task automatic push(input logic [7:0] b, input logic flip);
    int t;
    tx_data = b;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      timeout_fail("push_ready");
      tx_valid = 1'b0;
    end else begin
      acc_q.push_back(cyc + 1);
      exp_q.push_back({1'b1, (~^b) ^ flip, b, 1'b0});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (rx_q.size() < n) timeout_fail("wait_frames");
  endtask

  task automatic wait_bits(input int n);
    int t;
    t = 0;
    while (bitcnt < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (bitcnt < n) timeout_fail("wait_bits");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) timeout_fail("wait_idle");
  endtask

  task automatic check_frame(input bit chk_lat, input bit chk_gap);
    logic [10:0] e, r;
    int unsigned d, g, s, a;
    if (rx_q.size() == 0 || exp_q.size() == 0 || dur_q.size() == 0 ||
        gap_q.size() == 0 || start_q.size() == 0 || acc_q.size() == 0) begin
      timeout_fail("frame_missing");
      return;
    end
    e = exp_q.pop_front();
    r = rx_q.pop_front();
    d = dur_q.pop_front();
    g = gap_q.pop_front();
    s = start_q.pop_front();
    a = acc_q.pop_front();
    check("frame_bits", r, e);
    check("frame_len", d, 22 * HP);
    if (chk_lat) check("start_latency", s - a, 1);
    if (chk_gap) check_ge("inter_frame_gap", g, GAP);
    exp_sent++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    tx_valid = 1'b0;
    #1;
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    check("rst_tx_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    exp_q.delete();
    rx_q.delete();
    dur_q.delete();
    gap_q.delete();
    start_q.delete();
    acc_q.delete();
    exp_sent = 0;
  endtask

  initial begin
    int f0;
    clrn = 1'b1;
    #2;
    clrn = 1'b0;
    #1;
    check("por_ps2_clk", ps2_clk, 1);
    check("por_ps2_data", ps2_data, 1);
    check("por_busy", busy, 0);
    check("por_sent_cnt", sent_cnt, 0);
    check("por_tx_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    clrn = 1'b1;

    // Reset asserted in the middle of a frame
    @(negedge clk);
    push(8'hAA, 1'b0);
    tx_valid = 1'b0;
    wait_bits(3);
    do_reset();

    // Single byte 0x1C
    repeat (5) @(negedge clk);
    push(8'h1C, 1'b0);
    tx_valid = 1'b0;
    wait_frames(1);
    check_frame(1'b1, 1'b0);
    wait_idle();
    check("busy_drop_after_stop", cyc - last_rise, GAP);
    check("sent_single", sent_cnt, exp_sent);
    check("idle_clk_high", ps2_clk, 1);
    check("idle_data_high", ps2_data, 1);

    // Back-to-back 0xF0, 0x1C
    do_reset();
    @(negedge clk);
    push(8'hF0, 1'b0);
    push(8'h1C, 1'b0);
    tx_valid = 1'b0;
    wait_frames(2);
    check_frame(1'b1, 1'b0);
    check_frame(1'b0, 1'b1);
    wait_idle();
    check("sent_pair", sent_cnt, exp_sent);

    // Ten bytes on consecutive cycles: FIFO fills and the tenth is held
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 9; i++) push(8'(i), 1'b0);
    tx_data = 8'h09;
    check("tx_ready_full", tx_ready, 0);
    push(8'h09, 1'b0);
    tx_valid = 1'b0;
    wait_frames(10);
    for (int i = 0; i < 10; i++) check_frame(i == 0, i != 0);
    wait_idle();
    check("sent_ten", sent_cnt, exp_sent);

    // Reset during bit 5 of 0x55 with three bytes queued
    do_reset();
    @(negedge clk);
    push(8'h55, 1'b0);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    tx_valid = 1'b0;
    wait_bits(6);
    do_reset();
    f0 = falls;
    repeat (300) @(negedge clk);
    check("no_falls_after_rst", falls, f0);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_sent", sent_cnt, 0);
    check("post_rst_clk", ps2_clk, 1);
    check("post_rst_data", ps2_data, 1);

`ifdef PS2_TX_ERRINJ_EN
    // Parity corruption on one frame only
    do_reset();
    @(negedge clk);
    inject_err = 1'b1;
    push(8'h00, 1'b1);
    tx_valid = 1'b0;
    @(negedge clk);
    inject_err = 1'b0;
    push(8'h00, 1'b0);
    tx_valid = 1'b0;
    wait_frames(2);
    check_frame(1'b1, 1'b0);
    check_frame(1'b0, 1'b1);
    wait_idle();
    check("sent_errinj", sent_cnt, exp_sent);
`endif

    check("data_stable_while_clk_low", data_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
